// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register port.
// Contents:
//   state_t          - protocol FSM states
//   ACK_BIT/NAK_BIT  - SDA level of an acknowledge / not-acknowledge bit
//   DEV_ADDR_DEFAULT - default 7-bit target address
//   PTR_W_DEFAULT    - default register pointer width
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK_WAIT = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  localparam logic       ACK_BIT          = 1'b0;
  localparam logic       NAK_BIT          = 1'b1;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h70;
  localparam int         PTR_W_DEFAULT    = 7;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Register-port bundle between the I2C target and the register file.
// Ports (master = I2C target side):
//   reg_addr - current register pointer
//   wr_en    - one-clock write strobe, wr_data valid alongside
//   wr_data  - write data
//   rd_en    - one-clock read request for reg_addr
//   rd_data  - register value, valid the clock after rd_en
interface i2c_target_regs_if #(
  parameter int PTR_W = 7
) ();

  logic [PTR_W-1:0] reg_addr;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             rd_en;
  logic [7:0]       rd_data;

  modport master (
    output reg_addr,
    output wr_en,
    output wr_data,
    output rd_en,
    input  rd_data
  );

  modport slave (
    input  reg_addr,
    input  wr_en,
    input  wr_data,
    input  rd_en,
    output rd_data
  );

endinterface

// File: rtl/i2c_line_cond.sv
// Conditions the raw SCL/SDA pad inputs: two-flop synchronizer plus a
// history flop per line, and derives SCL edges, the sampled SDA level and
// START/STOP conditions.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   scl_in     - raw SCL (asynchronous)
//   sda_in     - raw SDA (asynchronous)
//   scl_rise   - one-clock pulse on a synchronized SCL rising edge
//   scl_fall   - one-clock pulse on a synchronized SCL falling edge
//   sda_level  - synchronized SDA level
//   start_det  - SDA fell while SCL high
//   stop_det   - SDA rose while SCL high
module i2c_line_cond (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_level,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_hist_r;
  logic       sda_hist_r;
  logic       sda_rise_s;
  logic       sda_fall_s;

  // Synchronizer and history flops; reset to the idle-bus level (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_hist_r <= scl_sync_r[1];
      sda_hist_r <= sda_sync_r[1];
    end
  end

  assign scl_rise   = scl_sync_r[1] & ~scl_hist_r;
  assign scl_fall   = ~scl_sync_r[1] & scl_hist_r;
  assign sda_rise_s = sda_sync_r[1] & ~sda_hist_r;
  assign sda_fall_s = ~sda_sync_r[1] & sda_hist_r;
  assign sda_level  = sda_sync_r[1];

  // Both lines pass through identical delays, so SDA changes made while SCL
  // is low can never be mistaken for START/STOP.
  assign start_det = sda_fall_s & scl_sync_r[1];
  assign stop_det  = sda_rise_s & scl_sync_r[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target (slave) that turns address + sub-address + data bytes into a
// simple register port with an auto-incrementing pointer.
// Ports:
//   clk, rst  - system clock (>= 10x SCL), synchronous active-high reset
//   scl_in    - raw SCL from pad
//   sda_in    - raw SDA from pad
//   sda_out   - constant 0 (open-drain data)
//   sda_oe    - 1 pulls SDA low
//   busy      - high from START until STOP
//   regs      - register port (reg_addr, wr_en, wr_data, rd_en, rd_data)
module i2c_target_regs import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         PTR_W    = PTR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              sda_oe,
  output logic              busy,
  i2c_target_regs_if.master regs
);

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic             scl_rise_s;
  logic             scl_fall_s;
  logic             sda_level_s;
  logic             start_s;
  logic             stop_s;
  logic [7:0]       byte_in_s;

  state_t           state_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic [7:0]       tx_r;
  logic [PTR_W-1:0] ptr_r;
  logic             rw_r;
  logic             sda_oe_r;
  logic             busy_r;
  logic             wr_en_r;
  logic [7:0]       wr_data_r;
  logic             rd_en_r;
  logic             latch_pend_r;

  i2c_line_cond u_line_cond (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .sda_level (sda_level_s),
    .start_det (start_s),
    .stop_det  (stop_s)
  );

  // Byte as it stands including the bit being sampled on this scl_rise.
  assign byte_in_s = {shift_r[6:0], sda_level_s};

  // Protocol FSM with register-port datapath.
  // In the *_ACK states sda_oe_r doubles as the phase flag: low means the
  // scl_fall that starts the ACK bit is still pending, high means the next
  // scl_fall ends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      tx_r         <= 8'h00;
      ptr_r        <= {PTR_W{1'b0}};
      rw_r         <= 1'b0;
      sda_oe_r     <= 1'b0;
      busy_r       <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_data_r    <= 8'h00;
      rd_en_r      <= 1'b0;
      latch_pend_r <= 1'b0;
    end else begin
      wr_en_r      <= 1'b0;
      rd_en_r      <= 1'b0;
      // rd_data is valid the clock after rd_en, so capture one clock later.
      latch_pend_r <= rd_en_r;
      if (latch_pend_r) begin
        tx_r <= regs.rd_data;
      end else begin
        tx_r <= tx_r;
      end
      // Write pointer advances the clock after the write strobe.
      if (wr_en_r) begin
        ptr_r <= ptr_r + PTR_ONE;
      end else begin
        ptr_r <= ptr_r;
      end

      if (stop_s) begin
        state_r  <= ST_IDLE;
        busy_r   <= 1'b0;
        sda_oe_r <= 1'b0;
      end else if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 3'd0;
        busy_r    <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE, ST_IGNORE: begin
            state_r <= state_r;
          end

          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r <= byte_in_s;
              if (bit_cnt_r == 3'd7) begin
                bit_cnt_r <= 3'd0;
                rw_r      <= sda_level_s;
                state_r   <= (shift_r[6:0] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_rise_s) begin
              rd_en_r <= rw_r;
            end else if (scl_fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else if (rw_r) begin
                state_r   <= ST_RDATA;
                bit_cnt_r <= 3'd0;
                sda_oe_r  <= ~tx_r[7];
              end else begin
                state_r   <= ST_SUB;
                bit_cnt_r <= 3'd0;
                sda_oe_r  <= 1'b0;
              end
            end
          end

          ST_SUB: begin
            if (scl_rise_s) begin
              shift_r <= byte_in_s;
              if (bit_cnt_r == 3'd7) begin
                bit_cnt_r <= 3'd0;
                ptr_r     <= byte_in_s[PTR_W-1:0];
                state_r   <= ST_SUB_ACK;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end

          ST_SUB_ACK, ST_WDATA_ACK: begin
            if (scl_rise_s) begin
              if (state_r == ST_WDATA_ACK) begin
                wr_en_r   <= 1'b1;
                wr_data_r <= shift_r;
              end else begin
                wr_en_r <= 1'b0;
              end
            end else if (scl_fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else begin
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 3'd0;
                state_r   <= ST_WDATA;
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise_s) begin
              shift_r <= byte_in_s;
              if (bit_cnt_r == 3'd7) begin
                bit_cnt_r <= 3'd0;
                state_r   <= ST_WDATA_ACK;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end

          ST_RDATA: begin
            // The bit on the wire is tx_r[7]; each scl_fall moves to the next.
            if (scl_fall_s) begin
              if (bit_cnt_r == 3'd7) begin
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 3'd0;
                ptr_r     <= ptr_r + PTR_ONE;
                state_r   <= ST_RACK_WAIT;
              end else begin
                tx_r      <= {tx_r[6:0], 1'b0};
                sda_oe_r  <= ~tx_r[6];
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end

          ST_RACK_WAIT: begin
            if (scl_rise_s) begin
              if (sda_level_s == ACK_BIT) begin
                rd_en_r <= 1'b1;
              end else begin
                state_r <= ST_IGNORE;
              end
            end else if (scl_fall_s) begin
              // Only reachable after an ACK: a NAK left this state already.
              state_r   <= ST_RDATA;
              bit_cnt_r <= 3'd0;
              sda_oe_r  <= ~tx_r[7];
            end
          end

          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_out       = 1'b0;
  assign sda_oe        = sda_oe_r;
  assign busy          = busy_r;
  assign regs.reg_addr = ptr_r;
  assign regs.wr_en    = wr_en_r;
  assign regs.wr_data  = wr_data_r;
  assign regs.rd_en    = rd_en_r;

endmodule

// File: tb/tb_i2c_target_regs.sv
module tb_i2c_target_regs;
  import i2c_pkg::*;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  logic sda_line;
  logic sda_out;
  logic sda_oe;
  logic busy;

  int checks = 0;
  int errors = 0;
  int ptr_m = 0;
  bit oe_seen = 1'b0;
  wr_t exp_wr[$];
  logic [6:0] exp_rd[$];
  logic [7:0] wbuf[4];

  i2c_target_regs_if #(.PTR_W(7)) regs_if ();

  // Open-drain bus with pull-up; register file returns addr + 0x80.
  assign sda_line = sda_drv & ~(sda_oe & ~sda_out);
  assign regs_if.rd_data = {1'b1, regs_if.reg_addr};

  i2c_target_regs dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_drv),
    .sda_in  (sda_line),
    .sda_out (sda_out),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .regs    (regs_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: pops expected strobes whenever the DUT issues one.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sda_oe) oe_seen = 1'b1;
        if (regs_if.wr_en || regs_if.rd_en) begin
          chk("strobe_excl", 32'(regs_if.wr_en & regs_if.rd_en), 32'd0);
          chk("strobe_busy", 32'(busy), 32'd1);
        end
        if (regs_if.wr_en) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: got addr %0d data %0h expected none",
                     regs_if.reg_addr, regs_if.wr_data);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(regs_if.reg_addr), 32'(e.a));
            chk("wr_data", 32'(regs_if.wr_data), 32'(e.d));
          end
        end
        if (regs_if.rd_en) begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got addr %0d expected none", regs_if.reg_addr);
          end else begin
            chk("rd_addr", 32'(regs_if.reg_addr), 32'(exp_rd.pop_front()));
          end
        end
      end
    end
  end

  // Bit-banged controller primitives (one SCL period = 20 clk).
  task automatic i2c_start();
    sda_drv = 1'b1; wclk(5);
    scl_drv = 1'b1; wclk(5);
    sda_drv = 1'b0; wclk(5);
    scl_drv = 1'b0; wclk(5);
    chk("busy_start", 32'(busy), 32'd1);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wclk(5);
    scl_drv = 1'b1; wclk(5);
    sda_drv = 1'b1; wclk(10);
    chk("busy_stop", 32'(busy), 32'd0);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; wclk(5);
    scl_drv = 1'b1; wclk(10);
    scl_drv = 1'b0; wclk(5);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[7-i]);
  endtask

  task automatic sample_bit(output logic b);
    sda_drv = 1'b1; wclk(5);
    scl_drv = 1'b1; wclk(5);
    b = sda_line; wclk(5);
    scl_drv = 1'b0; wclk(5);
  endtask

  // Write transaction: address, sub-address, n data bytes from wbuf.
  task automatic tx_write(input logic [6:0] dev, input logic [7:0] sub, input int n,
                          input bit do_stop);
    logic a;
    bit match;
    logic exp_ack;
    match = (dev == 7'h70);
    exp_ack = match ? ACK_BIT : NAK_BIT;
    i2c_start();
    send_bits({dev, 1'b0}, 8); sample_bit(a); chk("addr_ack", 32'(a), 32'(exp_ack));
    send_bits(sub, 8); sample_bit(a); chk("sub_ack", 32'(a), 32'(exp_ack));
    if (match) ptr_m = int'(sub) % 128;
    for (int i = 0; i < n; i++) begin
      if (match) exp_wr.push_back('{a: 7'(ptr_m), d: wbuf[i]});
      send_bits(wbuf[i], 8); sample_bit(a); chk("data_ack", 32'(a), 32'(exp_ack));
      if (match) ptr_m = (ptr_m + 1) % 128;
    end
    if (do_stop) i2c_stop();
  endtask

  // Read transaction of n bytes from the current pointer; last byte NAKed.
  task automatic tx_read(input int n);
    logic a;
    logic [7:0] b;
    i2c_start();
    exp_rd.push_back(7'(ptr_m));
    send_bits({7'h70, 1'b1}, 8); sample_bit(a); chk("raddr_ack", 32'(a), 32'(ACK_BIT));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        sample_bit(a);
        b = {b[6:0], a};
      end
      chk("rd_byte", 32'(b), 32'((ptr_m + 128) % 256));
      ptr_m = (ptr_m + 1) % 128;
      if (i < n - 1) begin
        exp_rd.push_back(7'(ptr_m));
        send_bit(ACK_BIT);
      end else begin
        send_bit(NAK_BIT);
      end
    end
    wclk(20);
    i2c_stop();
  endtask

  initial begin
    int waited;
    logic [7:0] sub;
    logic [6:0] dev;
    int kind;
    int n;

    wclk(5);
    rst = 1'b0;
    wclk(2);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(regs_if.wr_en), 32'd0);
    chk("rst_rd_en", 32'(regs_if.rd_en), 32'd0);
    chk("rst_reg_addr", 32'(regs_if.reg_addr), 32'd0);
    chk("rst_wr_data", 32'(regs_if.wr_data), 32'd0);

    // Basic two-byte write.
    wbuf[0] = 8'h55; wbuf[1] = 8'h1F;
    tx_write(7'h70, 8'd10, 2, 1'b1);

    // Pointer wrap on write.
    wbuf[0] = 8'hFA; wbuf[1] = 8'h4D;
    tx_write(7'h70, 8'd127, 2, 1'b1);

    // Sub-address then repeated START read with ACK then NAK.
    tx_write(7'h70, 8'd126, 0, 1'b0);
    tx_read(2);

    // Foreign address: SDA never pulled low.
    oe_seen = 1'b0;
    wbuf[0] = 8'h33;
    tx_write(7'h50, 8'd3, 1, 1'b1);
    chk("foreign_quiet", 32'(oe_seen), 32'd0);

    // Reset while the target holds the address ACK.
    i2c_start();
    send_bits(8'hE0, 8);
    sda_drv = 1'b1;
    waited = 0;
    while (!sda_oe && waited < 40) begin
      wclk(1);
      waited++;
    end
    if (!sda_oe) begin
      checks++; errors++;
      $display("FAIL ack_drive_timeout: got sda_oe 0 expected 1 within 40 clk");
    end
    rst = 1'b1;
    wclk(1);
    chk("rst_mid_release", 32'(sda_oe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    ptr_m = 0;
    wclk(5);
    wbuf[0] = 8'(($urandom));
    tx_write(7'h70, 8'd5, 1, 1'b1);

    // STOP in the middle of a data byte.
    tx_write(7'h70, 8'd20, 0, 1'b0);
    send_bits(8'(($urandom)), 4);
    i2c_stop();
    wclk(5);
    chk("midstop_no_wr", 32'(exp_wr.size()), 32'd0);
    wbuf[0] = 8'hC3;
    tx_write(7'h70, 8'd40, 1, 1'b1);

    // Randomized traffic against the pointer model.
    for (int it = 0; it < 15; it++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      sub = 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      case (kind)
        0: tx_write(7'h70, sub, n, 1'b1);
        1: begin
          tx_write(7'h70, sub, 0, 1'b0);
          tx_read(n);
        end
        default: begin
          dev = 7'($urandom_range(0, 127));
          if (dev == 7'h70) dev = 7'h71;
          oe_seen = 1'b0;
          tx_write(dev, sub, n, 1'b1);
          chk("rand_foreign_quiet", 32'(oe_seen), 32'd0);
        end
      endcase
      wclk(10);
    end

    wclk(20);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
